// File: rtl/rf_readback_serializer.sv
// Register-file readback serializer: waits for the read lines to settle, snapshots
// ports A and B, then shifts both words out MSB-first beside a generated shift clock.
module rf_readback_serializer #(
   parameter int WIDTH      = 32,
   parameter int DIV        = 4,
   parameter int SETTLE_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic [WIDTH-1:0] rla,
   input  logic [WIDTH-1:0] rlb,
   output logic             sclk,
   output logic             sdo_a,
   output logic             sdo_b,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   localparam int SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SHIFT  = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [SW-1:0]    set_cnt_r;
   logic [SW-1:0]    set_cnt_nxt_s;
   logic [DW-1:0]    div_cnt_r;
   logic [DW-1:0]    div_cnt_nxt_s;
   logic [DW-1:0]    div_inc_s;
   logic [BW-1:0]    bit_cnt_r;
   logic [BW-1:0]    bit_cnt_nxt_s;
   // Shift registers hold only the bits not yet presented on sdo_a/sdo_b.
   logic [WIDTH-1:0] shreg_a_r;
   logic [WIDTH-1:0] shreg_a_nxt_s;
   logic [WIDTH-1:0] shreg_b_r;
   logic [WIDTH-1:0] shreg_b_nxt_s;
   logic             sclk_nxt_s;
   logic             sdo_a_nxt_s;
   logic             sdo_b_nxt_s;
   logic             frame_nxt_s;
   logic             busy_nxt_s;
   logic             done_nxt_s;

   assign div_inc_s = div_cnt_r + DW'(1);

   // Next-state and next-output decode for the settle/shift sequencer.
   always_comb begin
      state_nxt_s   = state_r;
      set_cnt_nxt_s = set_cnt_r;
      div_cnt_nxt_s = div_cnt_r;
      bit_cnt_nxt_s = bit_cnt_r;
      shreg_a_nxt_s = shreg_a_r;
      shreg_b_nxt_s = shreg_b_r;
      sclk_nxt_s    = sclk;
      sdo_a_nxt_s   = sdo_a;
      sdo_b_nxt_s   = sdo_b;
      frame_nxt_s   = frame;
      busy_nxt_s    = busy;
      done_nxt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s   = ST_SETTLE;
               set_cnt_nxt_s = {SW{1'b0}};
               busy_nxt_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
               busy_nxt_s  = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (set_cnt_r == SET_LAST) begin
               state_nxt_s   = ST_SHIFT;
               shreg_a_nxt_s = {rla[WIDTH-2:0], 1'b0};
               shreg_b_nxt_s = {rlb[WIDTH-2:0], 1'b0};
               sdo_a_nxt_s   = rla[WIDTH-1];
               sdo_b_nxt_s   = rlb[WIDTH-1];
               frame_nxt_s   = 1'b1;
               sclk_nxt_s    = 1'b0;
               div_cnt_nxt_s = {DW{1'b0}};
               bit_cnt_nxt_s = {BW{1'b0}};
            end else begin
               set_cnt_nxt_s = set_cnt_r + SW'(1);
            end
         end
         ST_SHIFT: begin
            if (div_cnt_r != DIV_LAST) begin
               div_cnt_nxt_s = div_inc_s;
               sclk_nxt_s    = (div_inc_s >= DIV_HALF);
            end else if (bit_cnt_r != BIT_LAST) begin
               // Bit boundary: data advances together with the falling shift clock.
               div_cnt_nxt_s = {DW{1'b0}};
               bit_cnt_nxt_s = bit_cnt_r + BW'(1);
               sclk_nxt_s    = 1'b0;
               sdo_a_nxt_s   = shreg_a_r[WIDTH-1];
               sdo_b_nxt_s   = shreg_b_r[WIDTH-1];
               shreg_a_nxt_s = {shreg_a_r[WIDTH-2:0], 1'b0};
               shreg_b_nxt_s = {shreg_b_r[WIDTH-2:0], 1'b0};
            end else begin
               done_nxt_s    = 1'b1;
               frame_nxt_s   = 1'b0;
               sclk_nxt_s    = 1'b0;
               sdo_a_nxt_s   = 1'b0;
               sdo_b_nxt_s   = 1'b0;
               shreg_a_nxt_s = {WIDTH{1'b0}};
               shreg_b_nxt_s = {WIDTH{1'b0}};
               div_cnt_nxt_s = {DW{1'b0}};
               bit_cnt_nxt_s = {BW{1'b0}};
               if (cont) begin
                  state_nxt_s   = ST_SETTLE;
                  set_cnt_nxt_s = {SW{1'b0}};
                  busy_nxt_s    = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
                  busy_nxt_s  = 1'b0;
               end
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            set_cnt_nxt_s = {SW{1'b0}};
            div_cnt_nxt_s = {DW{1'b0}};
            bit_cnt_nxt_s = {BW{1'b0}};
            shreg_a_nxt_s = {WIDTH{1'b0}};
            shreg_b_nxt_s = {WIDTH{1'b0}};
            sclk_nxt_s    = 1'b0;
            sdo_a_nxt_s   = 1'b0;
            sdo_b_nxt_s   = 1'b0;
            frame_nxt_s   = 1'b0;
            busy_nxt_s    = 1'b0;
         end
      endcase
   end

   // State, counters, shift registers and every output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         set_cnt_r <= {SW{1'b0}};
         div_cnt_r <= {DW{1'b0}};
         bit_cnt_r <= {BW{1'b0}};
         shreg_a_r <= {WIDTH{1'b0}};
         shreg_b_r <= {WIDTH{1'b0}};
         sclk      <= 1'b0;
         sdo_a     <= 1'b0;
         sdo_b     <= 1'b0;
         frame     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         set_cnt_r <= set_cnt_nxt_s;
         div_cnt_r <= div_cnt_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         shreg_a_r <= shreg_a_nxt_s;
         shreg_b_r <= shreg_b_nxt_s;
         sclk      <= sclk_nxt_s;
         sdo_a     <= sdo_a_nxt_s;
         sdo_b     <= sdo_b_nxt_s;
         frame     <= frame_nxt_s;
         busy      <= busy_nxt_s;
         done      <= done_nxt_s;
      end
   end

endmodule

// File: tb/tb_rf_readback_serializer.sv
// Bench for rf_readback_serializer: a negedge monitor decodes the serial stream into
// words, and each scenario task compares against values derived from frame timing rules.
module tb_rf_readback_serializer;

   localparam int WIDTH      = 32;
   localparam int DIV        = 4;
   localparam int SETTLE_CYC = 3;
   localparam int LOAD_EDGE  = 1 + SETTLE_CYC;
   localparam int FRAME_CYC  = 1 + SETTLE_CYC + WIDTH * DIV;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             cont;
   logic [WIDTH-1:0] rla;
   logic [WIDTH-1:0] rlb;
   logic             sclk;
   logic             sdo_a;
   logic             sdo_b;
   logic             frame;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: words rebuilt from sdo sampled at each sclk rise, logged at every done.
   logic [WIDTH-1:0] cap_a = '0;
   logic [WIDTH-1:0] cap_b = '0;
   int               nbits = 0;
   logic             sclk_q = 1'b0;
   logic             frame_q = 1'b0;
   logic             sdo_a_q = 1'b0;
   logic             sdo_b_q = 1'b0;
   int               done_total = 0;
   int               frame_cycles = 0;
   int               edge_viol = 0;
   logic [WIDTH-1:0] fa_q[$];
   logic [WIDTH-1:0] fb_q[$];
   int               nb_q[$];

   rf_readback_serializer #(.WIDTH(WIDTH), .DIV(DIV), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .rla(rla), .rlb(rlb),
      .sclk(sclk), .sdo_a(sdo_a), .sdo_b(sdo_b), .frame(frame), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame === 1'b1 && frame_q !== 1'b1) begin
         cap_a = '0;
         cap_b = '0;
         nbits = 0;
      end
      if (sclk === 1'b1 && sclk_q !== 1'b1) begin
         cap_a = {cap_a[WIDTH-2:0], sdo_a};
         cap_b = {cap_b[WIDTH-2:0], sdo_b};
         nbits++;
      end
      if (frame === 1'b1 && frame_q === 1'b1 && (sdo_a !== sdo_a_q || sdo_b !== sdo_b_q)
          && !(sclk_q === 1'b1 && sclk === 1'b0))
         edge_viol++;
      if (frame !== 1'b1 && sclk !== 1'b0) edge_viol++;
      if (frame === 1'b1) frame_cycles++;
      if (done === 1'b1) begin
         done_total++;
         fa_q.push_back(cap_a);
         fb_q.push_back(cap_b);
         nb_q.push_back(nbits);
      end
      sclk_q  = sclk;
      frame_q = frame;
      sdo_a_q = sdo_a;
      sdo_b_q = sdo_b;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one frame from IDLE; len counts edges after the start edge until busy drops.
   task automatic drive_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input int chg_at, input logic [WIDTH-1:0] chg_a,
                              input bit scramble, input bit poke,
                              output int len, output logic done_end);
      rla = a;
      rlb = b;
      pulse_start();
      if (chg_at == 0) rla = chg_a;
      len = 0;
      while (busy === 1'b1 && len < 4 * FRAME_CYC) begin
         len++;
         start = (poke && (len == 10 || len == 60)) ? 1'b1 : 1'b0;
         tick();
         start = 1'b0;
         if (len == chg_at) rla = chg_a;
         if (scramble && len >= LOAD_EDGE) begin
            rla = $urandom;
            rlb = $urandom;
         end
      end
      done_end = done;
      tick();
   endtask

   task automatic test_reset();
      int d0;
      rst = 1'b1; start = 1'b0; cont = 1'b0; rla = '0; rlb = '0;
      repeat (3) tick();
      n_checks++;
      if ({sclk, sdo_a, sdo_b, frame, busy, done} !== 6'b0) begin
         n_fail++; $display("FAIL reset_hold: got %b want 000000", {sclk, sdo_a, sdo_b, frame, busy, done});
      end
      rst = 1'b0;
      rla = 32'hDEADBEEF; rlb = 32'hFFFFFFFF;
      pulse_start();
      repeat (40) tick();
      n_checks++;
      if (frame !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_active: got frame=%b busy=%b want 1 1", frame, busy);
      end
      d0 = done_total;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({sclk, sdo_a, sdo_b, frame, busy, done} !== 6'b0) begin
         n_fail++; $display("FAIL reset_async: got %b want 000000", {sclk, sdo_a, sdo_b, frame, busy, done});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         n_checks++;
         if ({sclk, sdo_a, sdo_b, frame, busy, done} !== 6'b0) begin
            n_fail++; $display("FAIL idle_after_reset cycle %0d: got %b want 000000", i,
                               {sclk, sdo_a, sdo_b, frame, busy, done});
         end
      end
      n_checks++;
      if (done_total != d0) begin
         n_fail++; $display("FAIL reset_no_done: got %0d done pulses want 0", done_total - d0);
      end
   endtask

   task automatic test_frame();
      logic [WIDTH-1:0] a, b;
      int len, d0, f0, v0, q0;
      logic done_end;
      for (int t = 0; t < 5; t++) begin
         if (t == 0) begin
            a = 32'hA5A50F0F; b = 32'h80000001;
         end else begin
            a = $urandom; b = $urandom;
         end
         d0 = done_total; f0 = frame_cycles; v0 = edge_viol; q0 = fa_q.size();
         drive_frame(a, b, -1, '0, t != 0, 1'b0, len, done_end);
         n_checks++;
         if (len != FRAME_CYC) begin
            n_fail++; $display("FAIL frame%0d_busy_len: got %0d want %0d", t, len, FRAME_CYC);
         end
         n_checks++;
         if (done_end !== 1'b1 || done !== 1'b0 || done_total - d0 != 1) begin
            n_fail++; $display("FAIL frame%0d_done_pulse: got end=%b next=%b count=%0d want 1 0 1",
                               t, done_end, done, done_total - d0);
         end
         n_checks++;
         if (fa_q.size() != q0 + 1 || fa_q[q0] !== a || fb_q[q0] !== b || nb_q[q0] != WIDTH) begin
            n_fail++; $display("FAIL frame%0d_data: got a=%h b=%h want a=%h b=%h", t,
                               cap_a, cap_b, a, b);
         end
         n_checks++;
         if (frame_cycles - f0 != WIDTH * DIV || edge_viol != v0) begin
            n_fail++; $display("FAIL frame%0d_shape: got frame_cycles=%0d viol=%0d want %0d 0", t,
                               frame_cycles - f0, edge_viol - v0, WIDTH * DIV);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [WIDTH-1:0] a, b;
      int len, d0;
      logic done_end;
      a = $urandom; b = $urandom;
      d0 = done_total;
      drive_frame(a, b, -1, '0, 1'b0, 1'b1, len, done_end);
      n_checks++;
      if (len != FRAME_CYC || done_end !== 1'b1) begin
         n_fail++; $display("FAIL ignore_len: got %0d done=%b want %0d 1", len, done_end, FRAME_CYC);
      end
      repeat (20) tick();
      n_checks++;
      if (busy !== 1'b0 || done_total - d0 != 1) begin
         n_fail++; $display("FAIL ignore_one_frame: got busy=%b frames=%0d want 0 1", busy, done_total - d0);
      end
      n_checks++;
      if (fa_q[fa_q.size()-1] !== a || fb_q[fb_q.size()-1] !== b) begin
         n_fail++; $display("FAIL ignore_data: got %h/%h want %h/%h", fa_q[fa_q.size()-1],
                            fb_q[fb_q.size()-1], a, b);
      end
   endtask

   task automatic test_snapshot();
      int chg_tab[6] = '{2, 4, 0, 3, 5, 1};
      logic [WIDTH-1:0] init, newv, want;
      int len, q0, chg;
      logic done_end;
      for (int t = 0; t < 8; t++) begin
         if (t < 2) begin
            init = 32'h0; newv = 32'hFFFFFFFF; chg = chg_tab[t];
         end else begin
            init = $urandom; newv = $urandom;
            chg  = (t < 6) ? chg_tab[t] : int'($urandom_range(0, 8));
         end
         want = (chg < LOAD_EDGE) ? newv : init;
         q0 = fa_q.size();
         drive_frame(init, ~init, chg, newv, 1'b0, 1'b0, len, done_end);
         n_checks++;
         if (fa_q.size() != q0 + 1 || fa_q[q0] !== want || fb_q[q0] !== ~init) begin
            n_fail++; $display("FAIL snapshot%0d_chg%0d: got %h want %h", t, chg, cap_a, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      int done_at[4];
      int n, k, d0, q0;
      logic [WIDTH-1:0] b;
      b = $urandom;
      cont = 1'b1; rla = 32'h12345678; rlb = b;
      repeat (10) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL cont_needs_start: got busy=%b want 0", busy);
      end
      d0 = done_total; q0 = fa_q.size(); k = 0; n = 0;
      pulse_start();
      while (n < 5 * FRAME_CYC) begin
         n++;
         tick();
         if (done === 1'b1) begin
            if (k < 4) done_at[k] = n;
            k++;
         end
         if (n == 2 * FRAME_CYC + 50) cont = 1'b0;
         if (busy !== 1'b1) break;
      end
      n_checks++;
      if (k != 3 || n != 3 * FRAME_CYC) begin
         n_fail++; $display("FAIL cont_frames: got %0d frames busy_end=%0d want 3 %0d", k, n, 3 * FRAME_CYC);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (k <= i || done_at[i] != (i + 1) * FRAME_CYC) begin
            n_fail++; $display("FAIL cont_done%0d_at: got %0d want %0d", i, (k > i) ? done_at[i] : -1,
                               (i + 1) * FRAME_CYC);
         end
      end
      repeat (20) tick();
      n_checks++;
      if (busy !== 1'b0 || done_total - d0 != 3) begin
         n_fail++; $display("FAIL cont_stop: got busy=%b frames=%0d want 0 3", busy, done_total - d0);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (fa_q.size() <= q0 + i || fa_q[q0+i] !== 32'h12345678 || fb_q[q0+i] !== b) begin
            n_fail++; $display("FAIL cont_data%0d: got %h want 12345678", i,
                               (fa_q.size() > q0 + i) ? fa_q[q0+i] : 32'hx);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [WIDTH-1:0] a, b;
      logic [16:0] first17;
      int len, d0, q0;
      logic done_end;
      a = $urandom; b = $urandom;
      first17 = a[WIDTH-1:WIDTH-17];
      rla = a; rlb = b;
      d0 = done_total;
      pulse_start();
      repeat (LOAD_EDGE + 17 * DIV + 1) tick();
      n_checks++;
      if (frame !== 1'b1 || nbits != 17 || cap_a[16:0] !== first17) begin
         n_fail++; $display("FAIL mid_position: got frame=%b bits=%0d head=%h want 1 17 %h",
                            frame, nbits, cap_a[16:0], first17);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({sclk, sdo_a, sdo_b, frame, busy, done} !== 6'b0) begin
         n_fail++; $display("FAIL mid_reset_async: got %b want 000000", {sclk, sdo_a, sdo_b, frame, busy, done});
      end
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (busy !== 1'b0 || done_total != d0) begin
         n_fail++; $display("FAIL mid_reset_no_done: got busy=%b done=%0d want 0 0", busy, done_total - d0);
      end
      a = $urandom; b = $urandom;
      q0 = fa_q.size();
      drive_frame(a, b, -1, '0, 1'b0, 1'b0, len, done_end);
      n_checks++;
      if (len != FRAME_CYC || fa_q.size() != q0 + 1 || fa_q[q0] !== a || fb_q[q0] !== b) begin
         n_fail++; $display("FAIL restart_frame: got len=%0d a=%h b=%h want %0d %h %h", len, cap_a, cap_b,
                            FRAME_CYC, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_start_ignored();
      test_snapshot();
      test_back_to_back();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
